// File: rtl/chan_pkg.sv
// Shared constants and helpers for the channel state memory arbiter.
package chan_pkg;

    localparam int CH_NUM       = 32;
    localparam int WORDS_PER_CH = 4;
    localparam int SEQ_AW       = 7;
    localparam int CPU_AW       = 9;
    localparam int CH_W         = 5;

    localparam logic [1:0] W_OFFS = 2'd0;
    localparam logic [1:0] W_ADDR = 2'd1;
    localparam logic [1:0] W_FRAC = 2'd2;
    localparam logic [1:0] W_VOL  = 2'd3;

    function automatic logic [3:0] lane_be(input logic [1:0] lane);
        lane_be = 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/chan_mem_starve.sv
// Starve counter: forces a CPU slot after STARVE_LIM consecutive
// sequencer wins over an eligible waiting CPU request.
module chan_mem_starve
    import chan_pkg::*;
#(
    parameter int STARVE_LIM = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic cpu_req,
    input  logic cpu_ok,
    input  logic seq_req,
    input  logic seq_gnt,
    input  logic cpu_ack,
    output logic force_slot
);

    logic [7:0] cnt;

    assign force_slot = (cnt == 8'(STARVE_LIM));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (!cpu_req || cpu_ack || force_slot) begin
            cnt <= '0;
        end else if (cpu_ok && seq_req && seq_gnt) begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/chan_mem_arb.sv
// Channel state RAM arbiter: sequencer priority, byte-wide CPU port.
// Optional starvation guard: define CHAN_MEM_ARB_STARVE_EN.
module chan_mem_arb
    import chan_pkg::*;
#(
    parameter int STARVE_LIM = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              seq_req,
    input  logic              seq_we,
    input  logic [SEQ_AW-1:0] seq_addr,
    input  logic [31:0]       seq_wdata,
    output logic              seq_gnt,
    output logic [31:0]       seq_rdata,
    output logic              seq_rvalid,
    input  logic              seq_lock,
    input  logic [CH_W-1:0]   seq_ch,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [CPU_AW-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_rvalid,
    output logic [SEQ_AW-1:0] mem_addr,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    if (STARVE_LIM < 1 || STARVE_LIM > 255) begin : g_lim_chk
        $error("STARVE_LIM out of range");
    end

    logic       cpu_blk;
    logic       cpu_ok;
    logic       cpu_pend;
    logic [1:0] lane_q;
    logic [7:0] byte_sel;

`ifdef CHAN_MEM_ARB_STARVE_EN
    logic force_slot;

    chan_mem_starve #(
        .STARVE_LIM(STARVE_LIM)
    ) u_starve (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_ok    (cpu_ok),
        .seq_req   (seq_req),
        .seq_gnt   (seq_gnt),
        .cpu_ack   (cpu_ack),
        .force_slot(force_slot)
    );
`endif

    // A CPU access to the channel the sequencer holds is never granted.
    always_comb begin
        cpu_blk = seq_lock && (cpu_addr[8:4] == seq_ch);
        cpu_ok  = cpu_req && !cpu_blk;
`ifdef CHAN_MEM_ARB_STARVE_EN
        seq_gnt = seq_req && !(force_slot && cpu_ok);
        cpu_ack = cpu_ok && (force_slot || !seq_req);
`else
        seq_gnt = seq_req;
        cpu_ack = cpu_ok && !seq_req;
`endif
    end

    always_comb begin
        mem_addr  = seq_addr;
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        mem_wdata = seq_wdata;
        unique case (1'b1)
            seq_gnt: begin
                mem_we = seq_we;
                mem_be = 4'hF;
            end
            cpu_ack: begin
                mem_addr  = cpu_addr[8:2];
                mem_we    = cpu_we;
                mem_be    = lane_be(cpu_addr[1:0]);
                mem_wdata = {4{cpu_wdata}};
            end
            default: ;
        endcase
    end

    always_comb begin
        byte_sel = mem_rdata[7:0];
        unique case (lane_q)
            2'd0: byte_sel = mem_rdata[7:0];
            2'd1: byte_sel = mem_rdata[15:8];
            2'd2: byte_sel = mem_rdata[23:16];
            2'd3: byte_sel = mem_rdata[31:24];
            default: ;
        endcase
    end

    assign seq_rdata = mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            seq_rvalid <= 1'b0;
            cpu_pend   <= 1'b0;
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            lane_q     <= '0;
        end else begin
            seq_rvalid <= seq_gnt && !seq_we;
            cpu_pend   <= cpu_ack && !cpu_we;
            cpu_rvalid <= cpu_pend;
            if (cpu_ack && !cpu_we) lane_q <= cpu_addr[1:0];
            if (cpu_pend) cpu_rdata <= byte_sel;
        end
    end

endmodule

// File: tb/tb_chan_mem_arb.sv
// Scoreboard bench for chan_mem_arb with a behavioural sync RAM.
module tb_chan_mem_arb;

    localparam int LIM = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        seq_req, seq_we, seq_gnt, seq_rvalid, seq_lock;
    logic [6:0]  seq_addr;
    logic [31:0] seq_wdata, seq_rdata;
    logic [4:0]  seq_ch;
    logic        cpu_req, cpu_we, cpu_ack, cpu_rvalid;
    logic [8:0]  cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic [6:0]  mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, mem_rdata;

    chan_mem_arb #(.STARVE_LIM(LIM)) dut (
        .clk(clk), .rst(rst),
        .seq_req(seq_req), .seq_we(seq_we), .seq_addr(seq_addr),
        .seq_wdata(seq_wdata), .seq_gnt(seq_gnt), .seq_rdata(seq_rdata),
        .seq_rvalid(seq_rvalid), .seq_lock(seq_lock), .seq_ch(seq_ch),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .cpu_rvalid(cpu_rvalid), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] ram [128];
    always @(posedge clk) begin
        if (mem_we)
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) ram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        mem_rdata <= ram[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    exp_t seq_q[$];
    exp_t cpu_q[$];
    exp_t se, ce;

    // Response monitor: checks data and arrival cycle of every rvalid.
    always @(negedge clk) begin
        if (seq_rvalid) begin
            if (seq_q.size() == 0) chk("seq_rvalid_unexpected", 1, 0);
            else begin
                se = seq_q.pop_front();
                chk("seq_latency", cyc, se.due);
                chk("seq_rdata", seq_rdata, se.data);
            end
        end else if (seq_q.size() > 0 && seq_q[0].due <= cyc) begin
            chk("seq_rvalid_missing", 0, 1);
            void'(seq_q.pop_front());
        end
        if (cpu_rvalid) begin
            if (cpu_q.size() == 0) chk("cpu_rvalid_unexpected", 1, 0);
            else begin
                ce = cpu_q.pop_front();
                chk("cpu_latency", cyc, ce.due);
                chk("cpu_rdata", {24'h0, cpu_rdata}, ce.data);
            end
        end else if (cpu_q.size() > 0 && cpu_q[0].due <= cyc) begin
            chk("cpu_rvalid_missing", 0, 1);
            void'(cpu_q.pop_front());
        end
    end

    // CPU must hold its fields while waiting for ack.
    logic       wait_q = 1'b0;
    logic       we_q;
    logic [8:0] addr_q;
    logic [7:0] wd_q;
    always @(posedge clk) begin
        if (wait_q && cpu_req)
            assert (cpu_we == we_q && cpu_addr == addr_q && cpu_wdata == wd_q)
            else $error("cpu fields changed while waiting for ack");
        wait_q <= cpu_req && !cpu_ack;
        we_q   <= cpu_we;
        addr_q <= cpu_addr;
        wd_q   <= cpu_wdata;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input logic [31:0] d);
        seq_q.push_back('{due: cyc + 1, data: d});
    endtask

    task automatic push_cpu(input logic [7:0] d);
        cpu_q.push_back('{due: cyc + 2, data: {24'h0, d}});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 128; i++) ram[i] = 32'h0;
        ram[3]  = 32'hDEADBEEF;
        ram[4]  = 32'h11223344;
        ram[16] = 32'h0BADF00D;
        rst = 1'b1;
        seq_req = 0; seq_we = 0; seq_addr = 0; seq_wdata = 0;
        seq_lock = 0; seq_ch = 0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        repeat (3) tick();
        #1;
        chk("rst_seq_rvalid", seq_rvalid, 0);
        chk("rst_cpu_rvalid", cpu_rvalid, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_be", mem_be, 0);
        rst = 1'b0;
        tick();
        tick();

        // CPU byte write, idle sequencer
        cpu_req = 1; cpu_we = 1; cpu_addr = 9'h005; cpu_wdata = 8'hA5;
        #1;
        chk("w_ack", cpu_ack, 1);
        chk("w_seq_gnt", seq_gnt, 0);
        chk("w_mem_addr", mem_addr, 7'd1);
        chk("w_mem_be", mem_be, 4'b0010);
        chk("w_mem_wdata", mem_wdata, 32'hA5A5A5A5);
        chk("w_mem_we", mem_we, 1);
        tick();
        cpu_req = 0; cpu_we = 0;

        // Sequencer reads
        seq_req = 1; seq_we = 0; seq_addr = 7'h04;
        #1;
        chk("sr_gnt", seq_gnt, 1);
        chk("sr_mem_be", mem_be, 4'hF);
        chk("sr_mem_we", mem_we, 0);
        push_seq(32'h11223344);
        tick();
        seq_addr = 7'h01;
        #1;
        chk("sr1_gnt", seq_gnt, 1);
        push_seq(32'h0000A500);
        tick();
        seq_req = 0;

        // CPU read lane 2 of word 4
        cpu_req = 1; cpu_we = 0; cpu_addr = 9'h012;
        #1;
        chk("cr_ack", cpu_ack, 1);
        chk("cr_mem_addr", mem_addr, 7'd4);
        chk("cr_mem_be", mem_be, 4'b0100);
        push_cpu(8'h22);
        tick();
        cpu_req = 0;
        repeat (3) tick();

        // Sequencer held for 20 cycles against a pending CPU read
        seq_req = 1; seq_addr = 7'h10;
        cpu_req = 1; cpu_we = 0; cpu_addr = 9'h00C;
        for (int i = 1; i <= 20; i++) begin
            logic exp_ack;
`ifdef CHAN_MEM_ARB_STARVE_EN
            exp_ack = (i == LIM + 1);
`else
            exp_ack = 1'b0;
`endif
            #1;
            chk("st_ack", cpu_ack, exp_ack);
            chk("st_seq_gnt", seq_gnt, !exp_ack);
            if (exp_ack) push_cpu(8'hEF);
            else push_seq(32'h0BADF00D);
            tick();
            if (exp_ack) cpu_req = 0;
        end
        seq_req = 0;
        #1;
`ifdef CHAN_MEM_ARB_STARVE_EN
        chk("st_end_ack", cpu_ack, 0);
`else
        chk("st_end_ack", cpu_ack, 1);
        push_cpu(8'hEF);
`endif
        tick();
        cpu_req = 0;
        repeat (3) tick();

        // Lock on channel 3 blocks CPU write to word 13
        seq_lock = 1; seq_ch = 5'd3;
        cpu_req = 1; cpu_we = 1; cpu_addr = 9'h034; cpu_wdata = 8'h5A;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("lk_ack", cpu_ack, 0);
            tick();
        end
        seq_ch = 5'd4;
        #1;
        chk("lk_rel_ack", cpu_ack, 1);
        chk("lk_mem_addr", mem_addr, 7'd13);
        chk("lk_mem_be", mem_be, 4'b0001);
        chk("lk_mem_wdata", mem_wdata, 32'h5A5A5A5A);
        tick();
        cpu_req = 0; cpu_we = 0; seq_lock = 0;

        // Simultaneous requests: sequencer write wins, CPU read follows
        seq_req = 1; seq_we = 1; seq_addr = 7'h20; seq_wdata = 32'hCAFEF00D;
        cpu_req = 1; cpu_we = 0; cpu_addr = 9'h034;
        #1;
        chk("sim_seq_gnt", seq_gnt, 1);
        chk("sim_cpu_ack", cpu_ack, 0);
        chk("sim_mem_wdata", mem_wdata, 32'hCAFEF00D);
        chk("sim_mem_we", mem_we, 1);
        tick();
        seq_req = 0; seq_we = 0;
        #1;
        chk("sim_drop_ack", cpu_ack, 1);
        chk("sim_mem_addr", mem_addr, 7'd13);
        push_cpu(8'h5A);
        tick();
        cpu_req = 0;
        seq_req = 1; seq_addr = 7'h20;
        #1;
        push_seq(32'hCAFEF00D);
        tick();
        seq_req = 0;
        repeat (3) tick();

        // Reset while reads are in flight
        cpu_req = 1; cpu_we = 0; cpu_addr = 9'h012;
        #1;
        chk("rr_cpu_ack", cpu_ack, 1);
        tick();
        cpu_req = 0;
        seq_req = 1; seq_addr = 7'h04; rst = 1;
        #1;
        chk("rr_seq_gnt", seq_gnt, 1);
        tick();
        rst = 0; seq_req = 0;
        #1;
        chk("rr_seq_rvalid", seq_rvalid, 0);
        chk("rr_cpu_rvalid", cpu_rvalid, 0);
        chk("rr_cpu_rdata", cpu_rdata, 0);
        tick();
        chk("rr_cpu_rvalid2", cpu_rvalid, 0);
        repeat (3) tick();
        chk("seq_q_drained", seq_q.size(), 0);
        chk("cpu_q_drained", cpu_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
